// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory stage issuing byte/half/word loads and stores to a variable-latency memory
module mem_access_unit #(
  parameter int RD_W = 5,
  parameter int WAIT_LIMIT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            exc_misalign,
  output logic            exc_bus
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic we_q, szb_q, szh_q, sgn_q;
  logic [1:0] lane_q;
  logic [RD_W-1:0] rd_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic ld, st, pass, szb, szh, szw, sgn, mis, take, acc;
  logic busy, done_st, done_ld, tout;
  logic [3:0] be;
  logic [31:0] wd, sh, ld_data;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic wbv_d, wbwe_d;
  logic [31:0] wbdata_d;
  assign ld   = in_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  assign st   = in_op inside {4'd6, 4'd7, 4'd8};
  assign pass = !(ld || st);
  assign szb  = in_op inside {4'd1, 4'd2, 4'd6};
  assign szh  = in_op inside {4'd3, 4'd4, 4'd7};
  assign szw  = in_op inside {4'd5, 4'd8};
  assign sgn  = in_op inside {4'd1, 4'd3};
  assign mis  = (szh && in_addr[0]) || (szw && in_addr[1:0] != 2'b00);
  assign in_ready = rst_n && state == IDLE;
  assign take = in_valid && state == IDLE;
  assign acc  = take && !pass && !mis;
  assign be = szb ? 4'b0001 << in_addr[1:0] : szh ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = szb ? {4{in_wdata[7:0]}} : szh ? {2{in_wdata[15:0]}} : in_wdata;
  // Lane extraction uses the address captured at accept, not the live bus.
  assign sh      = mem_rdata >> {lane_q, 3'b000};
  assign byte_v  = sh[7:0];
  assign half_v  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_data = szb_q ? {{24{sgn_q && byte_v[7]}}, byte_v} :
                   szh_q ? {{16{sgn_q && half_v[15]}}, half_v} : mem_rdata;
  assign busy    = state == REQ || state == WAIT;
  assign done_st = state == REQ && mem_gnt && we_q;
  assign done_ld = (state == REQ && mem_gnt && !we_q && mem_rvalid) || (state == WAIT && mem_rvalid);
  assign tout    = busy && cnt == LAST && !done_st && !done_ld;
  assign mem_req   = state == REQ;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  always_comb begin
    state_d  = state;
    wbv_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbdata_d = '0;
    state_d  = state == IDLE ? (acc ? REQ : IDLE) :
               state == REQ  ? (done_st || done_ld || tout ? IDLE : mem_gnt ? WAIT : REQ) :
               (done_ld || tout ? IDLE : WAIT);
    wbv_d    = (take && !acc) || done_st || done_ld || tout;
    wbwe_d   = take ? pass : done_ld;
    wbdata_d = take ? (pass ? in_addr : '0) : done_ld ? ld_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      {we_q, szb_q, szh_q, sgn_q, lane_q, rd_q, addr_q, be_q, wdata_q} <= '0;
      {wb_valid, wb_we, wb_rd, wb_data, exc_misalign, exc_bus} <= '0;
    end else begin
      state <= state_d;
      cnt <= acc ? '0 : busy ? cnt + 1'b1 : cnt;
      if (acc) begin
        we_q    <= st;
        szb_q   <= szb;
        szh_q   <= szh;
        sgn_q   <= sgn;
        lane_q  <= in_addr[1:0];
        rd_q    <= in_rd;
        addr_q  <= {in_addr[31:2], 2'b00};
        be_q    <= be;
        wdata_q <= wd;
      end
      wb_valid     <= wbv_d;
      exc_misalign <= take && !pass && mis;
      exc_bus      <= tout;
      if (wbv_d) begin
        wb_we   <= wbwe_d;
        wb_rd   <= take ? in_rd : rd_q;
        wb_data <= wbdata_d;
      end
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage sitting directly downstream of the registered ALU in the MIPS-54 dynamic pipeline.
- Takes the ALU result as effective address (or as a pass-through value), plus store data, destination register and memory op.
- Performs the byte/halfword/word load or store against a variable-latency data memory, then hands an aligned, extended result to writeback.
- Back-pressures the ALU stage with in_ready while a memory transaction is outstanding.

Parameters:
RD_W, 5, destination register index width
WAIT_LIMIT, 255, max cycles in REQ+WAIT before bus-error abort (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU stage presents an op this cycle
in_ready  out  1  unit accepts op (transfer = in_valid & in_ready)
in_op  in  4  0000 PASS, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 0110 SB, 0111 SH, 1000 SW, others = PASS
in_addr  in  32  ALU result r: effective address, or value for PASS
in_wdata  in  32  store data (rt)
in_rd  in  RD_W  destination register
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = store
mem_addr  out  32  word address, {in_addr[31:2],2'b00}
mem_be  out  4  byte enables (little-endian lanes, lane = addr[1:0])
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word
wb_valid  out  1  one-cycle result pulse to writeback (no back-pressure)
wb_we  out  1  1 = write wb_data to wb_rd
wb_rd  out  RD_W  destination register
wb_data  out  32  result
exc_misalign  out  1  qualifies wb_valid: misaligned access
exc_bus  out  1  qualifies wb_valid: timeout abort

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0, all outputs 0 except in_ready=1 once reset deasserts. Reset mid-transaction drops mem_req immediately; nothing is written back.
- States: IDLE, REQ, WAIT. in_ready = (state==IDLE).
- IDLE + transfer:
  - PASS: next cycle wb_valid=1, wb_we=1, wb_data=in_addr, wb_rd=in_rd.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no memory access; next cycle wb_valid=1, wb_we=0, wb_data=0, exc_misalign=1.
  - Otherwise: register op/addr/rd/lane; next cycle enter REQ with mem_req=1.
- Store data and enables:
  - SB: mem_wdata={4{wdata[7:0]}}, be=0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: mem_wdata=wdata, be=1111.
  - Loads: be computed the same way by size; mem_we=0.
- REQ: mem_req/we/addr/be/wdata held stable until mem_gnt.
  - Store + gnt: next cycle wb_valid=1, wb_we=0; return to IDLE.
  - Load + gnt without rvalid: go to WAIT; mem_req=0.
  - Load + gnt + rvalid in the same cycle: completes directly to writeback, as from WAIT.
- WAIT: on mem_rvalid, next cycle wb_valid=1, wb_we=1, with wb_data extracted from the captured lane:
  - LB/LBU: byte sign/zero-extended.
  - LH/LHU: half addr[1] sign/zero-extended.
  - LW: whole word.
  - Then return to IDLE.
- Timeout: counter clears on entering REQ and increments each cycle in REQ or WAIT. When it reaches WAIT_LIMIT without completion:
  - mem_req drops; next cycle wb_valid=1, wb_we=0, wb_data=0, exc_bus=1; return to IDLE.
  - A late mem_rvalid/mem_gnt in IDLE is ignored.
- Pulse rules: wb_valid, exc_misalign and exc_bus are single-cycle pulses; wb_* hold their last values when wb_valid=0.
- Throughput: PASS and misaligned ops sustain one per cycle. A memory op blocks new transfers from accept through the writeback cycle; in_ready rises in the wb_valid cycle.

Test Plan:
- PASS back-to-back: ops addr=0x1234, then 0xFFFF0000, rd=3,4 on consecutive cycles -> wb_valid two consecutive cycles with wb_data 0x1234 then 0xFFFF0000; in_ready stays 1.
- LB addr=0x103, mem_rdata=0x80FF_0000, gnt after 2 cycles, rvalid 3 cycles later -> mem_addr=0x100, be=1000, wb_data=0xFFFFFF80; in_ready=0 until the wb_valid cycle. Same access with LHU at addr=0x102 -> wb_data=0x000080FF.
- SH addr=0x202, wdata=0xDEADBEEF, gnt in the first REQ cycle -> mem_wdata=0xBEEFBEEF, be=1100, mem_we=1, then wb_valid=1 with wb_we=0.
- LW addr=0x6 -> no mem_req ever; wb_valid=1, exc_misalign=1, wb_we=0.
- LW with gnt+rvalid in the same REQ cycle, rdata=0x12345678 -> wb_data=0x12345678 one cycle later, never visits WAIT.
- WAIT_LIMIT=4, no gnt -> mem_req high for exactly 4 cycles, then exc_bus pulse. Assert rst_n=0 during REQ on a second run -> mem_req=0 immediately, no wb_valid.
